pow2_clock_divider_prog: RTL



---
 rtl/pow2_clkdiv_pkg.sv | 30 +++
 rtl/pow2_clkdiv_halfcnt.sv | 33 +++
 rtl/pow2_clock_divider_prog.sv | 105 ++++++++++
 3 files changed

// File: rtl/pow2_clkdiv_pkg.sv
// Shared types and elaboration-time helpers for the programmable power-of-two clock divider.
package pow2_clkdiv_pkg;

  typedef enum logic [0:0] {
    StStopped,
    StRun
  } state_e;

  // Counter width: must hold 2^max_log2 - 1, never narrower than one bit.
  function automatic int unsigned calc_cw(input int unsigned max_log2);
    return (max_log2 < 1) ? 1 : max_log2;
  endfunction

  // Ratio code width: enough bits for codes 0..max_log2.
  function automatic int unsigned calc_rw(input int unsigned max_log2);
    int unsigned w;
    w = $clog2(max_log2 + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned sat_log2(input int unsigned code, input int unsigned max_log2);
    return (code > max_log2) ? max_log2 : code;
  endfunction

  // Terminal count of a half period: h - 1 = 2^log2 - 1.
  function automatic int unsigned half_term(input int unsigned log2);
    return (32'd1 << log2) - 32'd1;
  endfunction

endpackage

// File: rtl/pow2_clkdiv_halfcnt.sv
// Half-period counter: counts 0..term_i while running, flags the terminal count, idles at zero.
module pow2_clkdiv_halfcnt #(
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  input  logic [CW-1:0] term_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = run_i && (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || tc_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pow2_clock_divider_prog.sv
// Runtime-programmable power-of-two clock divider with glitch-free ratio changes applied
// at the falling edge of the divided clock and a clean enable stop/start.
module pow2_clock_divider_prog
  import pow2_clkdiv_pkg::*;
#(
  parameter int unsigned MAX_LOG2   = 4,
  parameter int unsigned RESET_LOG2 = 0,
  parameter int unsigned CW         = calc_cw(MAX_LOG2),
  parameter int unsigned RW         = calc_rw(MAX_LOG2)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          io_en,
  input  logic          io_req_valid,
  output logic          io_req_ready,
  input  logic [RW-1:0] io_req_log2,
  output logic          io_ack,
  output logic [RW-1:0] io_ratio_log2,
  output logic          io_running,
  output logic          io_clock_out,
  output logic          io_rise_pulse
);

  state_e        state_q;
  logic          clk_out_q;
  logic [RW-1:0] active_q;
  logic [RW-1:0] pending_q;
  logic          pending_v_q;
  logic          ack_q;

  logic          run;
  logic          tc;
  logic          accept;
  logic [CW-1:0] term;
  logic [RW-1:0] req_sat;

  assign run     = (state_q == StRun);
  assign accept  = io_req_valid && !pending_v_q;
  assign term    = CW'(half_term(32'(active_q)));
  assign req_sat = RW'(sat_log2(32'(io_req_log2), MAX_LOG2));

  pow2_clkdiv_halfcnt #(
    .CW(CW)
  ) u_halfcnt (
    .clk_i (clock),
    .rst_ni(reset_n),
    .run_i (run),
    .term_i(term),
    .tc_o  (tc)
  );

  // Ratio swaps and stops happen only when the high phase ends, so no phase is ever cut short.
  // A request accepted on that same edge is left pending for the next boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StStopped;
      clk_out_q   <= 1'b0;
      active_q    <= RW'(RESET_LOG2);
      pending_q   <= '0;
      pending_v_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (accept) begin
        pending_v_q <= 1'b1;
        pending_q   <= req_sat;
      end
      unique case (state_q)
        StStopped: begin
          clk_out_q <= 1'b0;
          if (pending_v_q) begin
            active_q    <= pending_q;
            pending_v_q <= 1'b0;
            ack_q       <= 1'b1;
          end else if (io_en) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (tc) begin
            clk_out_q <= ~clk_out_q;
            if (clk_out_q) begin
              if (pending_v_q) begin
                active_q    <= pending_q;
                pending_v_q <= 1'b0;
                ack_q       <= 1'b1;
              end
              if (!io_en) begin
                state_q <= StStopped;
              end
            end
          end
        end
      endcase
    end
  end

  assign io_req_ready  = !pending_v_q;
  assign io_ack        = ack_q;
  assign io_ratio_log2 = active_q;
  assign io_running    = run;
  assign io_clock_out  = clk_out_q;
  assign io_rise_pulse = tc && !clk_out_q;

endmodule
